wbu: RTL and testbench

//  Write-back stage of the multi-cycle core, directly downstream of the load/store unit.

---
 rtl/wbu.sv | 204 ++++++++++++++++++++
 tb/tb_wbu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// ----------------------------------------------------------------------------
// wbu -- write-back unit of the multi-cycle core.
//
// Sits directly downstream of the load/store unit. A one-cycle
// wbu_receive_valid pulse hands over the results of one retiring instruction.
// Every field is latched, and wbu_send_ready is pulsed on the next cycle.
// On the clock edge that follows, the GPR and CSR writes are committed,
// pc_out is updated, and wbu_send_valid is pulsed towards fetch.
//
// The unit owns the architectural register file and the four machine CSRs
// (mstatus, mtvec, mepc, mcause). Decode reads them through combinational
// ports. These ports are not bypassed, so a register that is being committed
// reads its old value until the commit edge.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   wbu_receive_valid     result fields from the LSU are valid this cycle
//   wd, rd, reg_write_en  GPR write data / index / enable
//   csr_wd, csr_rd,
//   csreg_write_en        CSR write data / select / enable
//   ecall                 retiring instruction is ecall (sets mcause/mepc)
//   pc_next               next PC computed upstream
//   rs1, rs2, csr_rs      decode read indices
//   src1, src2, csr_rdata combinational read data (x0 reads as 0)
//   mtvec_o               current trap vector
//   wbu_send_ready        one-cycle pulse: instruction accepted
//   wbu_send_valid        one-cycle pulse: commit done, pc_out valid
//   pc_out                PC of the last commit, held until the next one
//   retired               committed-instruction counter (wraps)
// ----------------------------------------------------------------------------
module wbu #(
    parameter int          NREGS       = 32,
    parameter logic [31:0] MSTATUS_RST = 32'h1800,
    parameter int          CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wbu_receive_valid,
    input  logic [31:0]      wd,
    input  logic [31:0]      csr_wd,
    input  logic [4:0]       rd,
    input  logic [1:0]       csr_rd,
    input  logic             reg_write_en,
    input  logic             csreg_write_en,
    input  logic             ecall,
    input  logic [31:0]      pc_next,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [1:0]       csr_rs,
    output logic [31:0]      src1,
    output logic [31:0]      src2,
    output logic [31:0]      csr_rdata,
    output logic [31:0]      mtvec_o,
    output logic             wbu_send_ready,
    output logic             wbu_send_valid,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] retired
);

    localparam int IDXW = $clog2(NREGS);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] COMMIT = 1'b1;

    localparam logic [1:0] CSR_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_MTVEC   = 2'd1;
    localparam logic [1:0] CSR_MEPC    = 2'd2;
    localparam logic [1:0] CSR_MCAUSE  = 2'd3;

    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    logic [0:0]       state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [31:0]      pc_out_q;
    logic [CNT_W-1:0] retired_q;

    // Fields latched at acceptance, consumed on the commit edge.
    logic [31:0]      wd_q;
    logic [31:0]      csr_wd_q;
    logic [IDXW-1:0]  rd_q;
    logic [1:0]       csr_rd_q;
    logic             reg_we_q;
    logic             csr_we_q;
    logic             ecall_q;
    logic [31:0]      pc_next_q;

    logic [31:0] regs_q [NREGS];
    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;

    logic accept;

    // Handshake is only taken from IDLE; a pulse arriving during COMMIT is dropped.
    assign accept = (state_q == IDLE) && wbu_receive_valid;

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbu_receive_valid) begin
                    state_d = COMMIT;
                    ready_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            pc_out_q  <= '0;
            retired_q <= '0;
            wd_q      <= '0;
            csr_wd_q  <= '0;
            rd_q      <= '0;
            csr_rd_q  <= '0;
            reg_we_q  <= 1'b0;
            csr_we_q  <= 1'b0;
            ecall_q   <= 1'b0;
            pc_next_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            if (accept) begin
                wd_q      <= wd;
                csr_wd_q  <= csr_wd;
                rd_q      <= rd[IDXW-1:0];
                csr_rd_q  <= csr_rd;
                reg_we_q  <= reg_write_en;
                csr_we_q  <= csreg_write_en;
                ecall_q   <= ecall;
                pc_next_q <= pc_next;
            end
            if (state_q == COMMIT) begin
                pc_out_q  <= pc_next_q;
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Register file commit; x0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == COMMIT && reg_we_q && rd_q != '0) begin
            regs_q[rd_q] <= wd_q;
        end
    end

    // CSR commit. The ecall updates come last so they override a generic
    // write aimed at mepc or mcause in the same instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else if (state_q == COMMIT) begin
            if (csr_we_q) begin
                case (csr_rd_q)
                    CSR_MSTATUS: mstatus_q <= csr_wd_q;
                    CSR_MTVEC:   mtvec_q   <= csr_wd_q;
                    CSR_MEPC:    mepc_q    <= csr_wd_q;
                    default:     mcause_q  <= csr_wd_q;
                endcase
            end
            if (ecall_q) begin
                mcause_q <= CAUSE_ECALL_M;
                mepc_q   <= csr_wd_q;
            end
        end
    end

    always_comb begin
        src1 = (rs1[IDXW-1:0] == '0) ? 32'd0 : regs_q[rs1[IDXW-1:0]];
        src2 = (rs2[IDXW-1:0] == '0) ? 32'd0 : regs_q[rs2[IDXW-1:0]];
        case (csr_rs)
            CSR_MSTATUS: csr_rdata = mstatus_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            default:     csr_rdata = mcause_q;
        endcase
    end

    assign mtvec_o        = mtvec_q;
    assign wbu_send_ready = ready_q;
    assign wbu_send_valid = valid_q;
    assign pc_out         = pc_out_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_wbu.sv
// ----------------------------------------------------------------------------
// tb_wbu -- directed, table-driven bench for the write-back unit.
// Each table row is one instruction together with its hand-computed register
// and CSR values: the value before the commit, the value after it, the
// expected mtvec and the expected pc_out. Hand-written sequences cover a
// repeated valid pulse during COMMIT and a reset taken mid-COMMIT.
// ----------------------------------------------------------------------------
module tb_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbu_receive_valid;
    logic [31:0] wd, csr_wd, pc_next;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  csr_rd, csr_rs;
    logic        reg_write_en, csreg_write_en, ecall;
    logic [31:0] src1, src2, csr_rdata, mtvec_o, pc_out;
    logic        wbu_send_ready, wbu_send_valid;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;

    wbu dut (
        .clk               (clk),
        .rst               (rst),
        .wbu_receive_valid (wbu_receive_valid),
        .wd                (wd),
        .csr_wd            (csr_wd),
        .rd                (rd),
        .csr_rd            (csr_rd),
        .reg_write_en      (reg_write_en),
        .csreg_write_en    (csreg_write_en),
        .ecall             (ecall),
        .pc_next           (pc_next),
        .rs1               (rs1),
        .rs2               (rs2),
        .csr_rs            (csr_rs),
        .src1              (src1),
        .src2              (src2),
        .csr_rdata         (csr_rdata),
        .mtvec_o           (mtvec_o),
        .wbu_send_ready    (wbu_send_ready),
        .wbu_send_valid    (wbu_send_valid),
        .pc_out            (pc_out),
        .retired           (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        we;
        logic [1:0]  csrRd;
        logic [31:0] csrWd;
        logic        csrWe;
        logic        ecall;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [31:0] gprOld;
        logic [31:0] gprNew;
        logic [1:0]  csrRs;
        logic [31:0] csrOld;
        logic [31:0] csrNew;
        logic [31:0] mtvecExp;
    } vec_t;

    vec_t vecs [7];

    // Compares one value and records the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one instruction's fields and raises receive_valid; called at a negedge.
    task automatic applyStimulus(input vec_t v);
        rd                = v.rd;
        wd                = v.wd;
        reg_write_en      = v.we;
        csr_rd            = v.csrRd;
        csr_wd            = v.csrWd;
        csreg_write_en    = v.csrWe;
        ecall             = v.ecall;
        pc_next           = v.pc;
        rs1               = v.rs;
        rs2               = v.rs;
        csr_rs            = v.csrRs;
        wbu_receive_valid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{5'd5,  32'hDEADBEEF, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 32'h80000004,
                    5'd5,  32'h0,        32'hDEADBEEF, 2'd0, 32'h1800, 32'h1800, 32'h0};
        vecs[1] = '{5'd0,  32'h00001234, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 32'h80000008,
                    5'd0,  32'h0,        32'h0,        2'd0, 32'h1800, 32'h1800, 32'h0};
        vecs[2] = '{5'd31, 32'hA5A5A5A5, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h8000000C,
                    5'd31, 32'h0,        32'h0,        2'd1, 32'h0,    32'h0,    32'h0};
        vecs[3] = '{5'd31, 32'h0F0F0F0F, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 32'h80000010,
                    5'd31, 32'h0,        32'h0F0F0F0F, 2'd1, 32'h0,    32'h0,    32'h0};
        vecs[4] = '{5'd5,  32'h11111111, 1'b0, 2'd1, 32'h80001000, 1'b1, 1'b0, 32'h80000014,
                    5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'd1, 32'h0, 32'h80001000, 32'h80001000};
        vecs[5] = '{5'd3,  32'h22222222, 1'b0, 2'd0, 32'h80000010, 1'b0, 1'b1, 32'h80001000,
                    5'd3,  32'h0,        32'h0,        2'd3, 32'h0,    32'd11,   32'h80001000};
        vecs[6] = '{5'd0,  32'h0,        1'b0, 2'd0, 32'h00000088, 1'b1, 1'b0, 32'h80001004,
                    5'd31, 32'h0F0F0F0F, 32'h0F0F0F0F, 2'd0, 32'h1800, 32'h88, 32'h80001000};

        rst = 1'b1;
        wbu_receive_valid = 1'b0;
        wd = '0; csr_wd = '0; pc_next = '0; rd = '0; rs1 = '0; rs2 = '0;
        csr_rd = '0; csr_rs = '0; reg_write_en = 1'b0; csreg_write_en = 1'b0; ecall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(i);
            #1;
            checkOutput($sformatf("reset_x%0d_src1", i), 64'(src1), 64'h0);
            checkOutput($sformatf("reset_x%0d_src2", i), 64'(src2), 64'h0);
        end
        csr_rs = 2'd0; #1; checkOutput("reset_mstatus", 64'(csr_rdata), 64'h1800);
        csr_rs = 2'd1; #1; checkOutput("reset_mtvec",   64'(csr_rdata), 64'h0);
        csr_rs = 2'd2; #1; checkOutput("reset_mepc",    64'(csr_rdata), 64'h0);
        csr_rs = 2'd3; #1; checkOutput("reset_mcause",  64'(csr_rdata), 64'h0);
        checkOutput("reset_ready",   64'(wbu_send_ready), 64'h0);
        checkOutput("reset_valid",   64'(wbu_send_valid), 64'h0);
        checkOutput("reset_retired", retired, 64'h0);
        checkOutput("reset_pc_out",  64'(pc_out), 64'h0);

        // Table: one instruction per row, checking the latency and the commit.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            applyStimulus(vecs[k]);
            @(negedge clk);
            wbu_receive_valid = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_ready_n1", k), 64'(wbu_send_ready), 64'h1);
            checkOutput($sformatf("v%0d_valid_n1", k), 64'(wbu_send_valid), 64'h0);
            checkOutput($sformatf("v%0d_src1_old", k), 64'(src1), 64'(vecs[k].gprOld));
            checkOutput($sformatf("v%0d_csr_old", k), 64'(csr_rdata), 64'(vecs[k].csrOld));
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d_ready_n2", k), 64'(wbu_send_ready), 64'h0);
            checkOutput($sformatf("v%0d_valid_n2", k), 64'(wbu_send_valid), 64'h1);
            checkOutput($sformatf("v%0d_src1_new", k), 64'(src1), 64'(vecs[k].gprNew));
            checkOutput($sformatf("v%0d_src2_new", k), 64'(src2), 64'(vecs[k].gprNew));
            checkOutput($sformatf("v%0d_csr_new", k), 64'(csr_rdata), 64'(vecs[k].csrNew));
            checkOutput($sformatf("v%0d_mtvec", k), 64'(mtvec_o), 64'(vecs[k].mtvecExp));
            checkOutput($sformatf("v%0d_pc_out", k), 64'(pc_out), 64'(vecs[k].pc));
            checkOutput($sformatf("v%0d_retired", k), retired, 64'(k + 1));
            @(negedge clk);
            checkOutput($sformatf("v%0d_valid_n3", k), 64'(wbu_send_valid), 64'h0);
        end
        csr_rs = 2'd2; #1;
        checkOutput("ecall_mepc", 64'(csr_rdata), 64'h80000010);
        csr_rs = 2'd3; #1;
        checkOutput("ecall_mcause", 64'(csr_rdata), 64'd11);

        // A second receive pulse during COMMIT must be ignored.
        begin
            int readyCnt;
            int validCnt;
            readyCnt = 0;
            validCnt = 0;
            @(negedge clk);
            rd = 5'd7; wd = 32'h00001111; reg_write_en = 1'b1;
            csreg_write_en = 1'b0; ecall = 1'b0; pc_next = 32'h90000000;
            wbu_receive_valid = 1'b1;
            @(negedge clk);
            readyCnt += int'(wbu_send_ready);
            validCnt += int'(wbu_send_valid);
            rd = 5'd8; wd = 32'h00002222; pc_next = 32'h90000004;
            @(negedge clk);
            wbu_receive_valid = 1'b0;
            readyCnt += int'(wbu_send_ready);
            validCnt += int'(wbu_send_valid);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                readyCnt += int'(wbu_send_ready);
                validCnt += int'(wbu_send_valid);
            end
            checkOutput("dbl_ready_count", 64'(readyCnt), 64'd1);
            checkOutput("dbl_valid_count", 64'(validCnt), 64'd1);
            checkOutput("dbl_retired", retired, 64'd8);
            checkOutput("dbl_pc_out", 64'(pc_out), 64'h90000000);
            rs1 = 5'd7; rs2 = 5'd8; #1;
            checkOutput("dbl_x7", 64'(src1), 64'h1111);
            checkOutput("dbl_x8", 64'(src2), 64'h0);
        end

        // Reset while in COMMIT: the pending write is dropped.
        begin
            int validCnt;
            validCnt = 0;
            @(negedge clk);
            rd = 5'd9; wd = 32'h00009999; reg_write_en = 1'b1;
            csr_rd = 2'd1; csr_wd = 32'h12345678; csreg_write_en = 1'b1;
            pc_next = 32'hA0000000;
            wbu_receive_valid = 1'b1;
            @(negedge clk);
            wbu_receive_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 3; c++) begin
                validCnt += int'(wbu_send_valid);
                @(negedge clk);
            end
            rs1 = 5'd9; rs2 = 5'd5; csr_rs = 2'd0; #1;
            checkOutput("rstc_valid_count", 64'(validCnt), 64'd0);
            checkOutput("rstc_x9", 64'(src1), 64'h0);
            checkOutput("rstc_x5", 64'(src2), 64'h0);
            checkOutput("rstc_mtvec", 64'(mtvec_o), 64'h0);
            checkOutput("rstc_mstatus", 64'(csr_rdata), 64'h1800);
            checkOutput("rstc_retired", retired, 64'h0);
            checkOutput("rstc_pc_out", 64'(pc_out), 64'h0);
            checkOutput("rstc_ready", 64'(wbu_send_ready), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
